regfile_mp: RTL and testbench

- Parametrised multi-read-port register file; successor to the fixed 32x32, 2-read/1-write regfile in the core datapath.
- Generalised in width, depth and read-port count.
- Adds an async-reset array, optional hardwired entry 0, and a hardware clear sweep with busy/done handshake.
- Optional write-to-read bypass.
- Sits in the decode stage, feeding operand muxes.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_clr_fsm.sv | 60 ++++++
 rtl/regfile_mp.sv | 74 +++++++
 tb/tb_regfile_mp.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-read-port register file.
package regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int AW_DEF   = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clr_state_t;

   // Low bit index of lane p in a packed bus of w-bit lanes.
   function automatic int unsigned lane_lo(input int unsigned p, input int unsigned w);
      return p * w;
   endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep controller: walks every entry once, raising clr_busy for DEPTH
// cycles and pulsing clr_done when the last entry has been cleared.
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done,
   output logic          clr_en,
   output logic [AW-1:0] clr_idx
);

   clr_state_t    state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_busy  = 1'b0;
      clr_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (clr_req) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            // clr_req is deliberately ignored here; the counter wraps to 0 on the last entry
            clr_busy = 1'b1;
            cnt_nxt  = cnt + 1'b1;
            if (cnt == '1) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            clr_done  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = clr_req ? ST_CLEAR : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign clr_en  = clr_busy;
   assign clr_idx = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with clear sweep and optional
// hardwired entry 0. Define REGFILE_BYPASS_EN to forward accepted writes to reads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int AW       = AW_DEF,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [AW-1:0]       wa,
   input  logic [XLEN-1:0]     wd,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rd,
   input  logic                clr_req,
   output logic                clr_busy,
   output logic                clr_done,
   output logic                wr_drop
);

   localparam int DEPTH = 2 ** AW;

   logic [XLEN-1:0] mem [DEPTH];
   logic            clr_en;
   logic [AW-1:0]   clr_idx;
   logic            wa_zero;
   logic            wr_acc;

   regfile_clr_fsm #(.AW(AW)) u_clr_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_en   (clr_en),
      .clr_idx  (clr_idx)
   );

   // Writes to a hardwired entry 0 vanish silently: neither stored nor reported as dropped.
   assign wa_zero = (ZERO_REG != 0) && (wa == '0);
   assign wr_acc  = we && !clr_busy && !wa_zero;
   assign wr_drop = we &&  clr_busy && !wa_zero;

   for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      logic [XLEN-1:0] q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            q <= '0;
         else if (clr_en && (clr_idx == AW'(e)))
            q <= '0;
         else if (wr_acc && (wa == AW'(e)))
            q <= wd;
      end

      assign mem[e] = q;
   end

   always_comb begin
      rd = '0;
      for (int p = 0; p < NRD; p++) begin
         if (!((ZERO_REG != 0) && (ra[lane_lo(p, AW) +: AW] == '0)))
            rd[lane_lo(p, XLEN) +: XLEN] = mem[ra[lane_lo(p, AW) +: AW]];
`ifdef REGFILE_BYPASS_EN
         if (wr_acc && (ra[lane_lo(p, AW) +: AW] == wa))
            rd[lane_lo(p, XLEN) +: XLEN] = wd;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: directed checks on a 32x32/2-port instance and a
// randomized run on an 8x16/4-port instance against a shadow model.
`timescale 1ns/1ps
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // instance A: XLEN=32, AW=5, NRD=2, ZERO_REG=1
   logic        a_we, a_clr_req, a_busy, a_done, a_drop;
   logic [4:0]  a_wa;
   logic [31:0] a_wd;
   logic [9:0]  a_ra;
   logic [63:0] a_rd;

   // instance B: XLEN=16, AW=3, NRD=4, ZERO_REG=0
   logic        b_we, b_clr_req, b_busy, b_done, b_drop;
   logic [2:0]  b_wa;
   logic [15:0] b_wd;
   logic [11:0] b_ra;
   logic [63:0] b_rd;

   regfile_mp #(.XLEN(32), .AW(5), .NRD(2), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .we(a_we), .wa(a_wa), .wd(a_wd), .ra(a_ra), .rd(a_rd),
      .clr_req(a_clr_req), .clr_busy(a_busy), .clr_done(a_done), .wr_drop(a_drop)
   );

   regfile_mp #(.XLEN(16), .AW(3), .NRD(4), .ZERO_REG(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .we(b_we), .wa(b_wa), .wd(b_wd), .ra(b_ra), .rd(b_rd),
      .clr_req(b_clr_req), .clr_busy(b_busy), .clr_done(b_done), .wr_drop(b_drop)
   );

   int total = 0;
   int bad   = 0;
   int nb, nd, nz;

   // shadow model for instance B
   logic [15:0] m [8];
   int          pos;
   bit          dn;
   bit          busy_e, acc;
   logic [2:0]  ra_v;
   logic [15:0] e_rd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_fill(input logic [31:0] v);
      for (int i = 0; i < 32; i++) begin
         a_we = 1'b1; a_wa = 5'(i); a_wd = v;
         step();
      end
      a_we = 1'b0;
   endtask

   task automatic a_count_nonzero(output int n);
      n = 0;
      for (int i = 0; i < 32; i++) begin
         a_ra = {5'(31 - i), 5'(i)};
         #1;
         if (a_rd !== 64'd0) n++;
      end
   endtask

   // Starts a sweep on A and watches it for 40 cycles; at busy cycle inj a
   // write (plus a second clr_req) is attempted.
   task automatic a_sweep(input int inj, output int n_busy, output int n_done);
      a_we = 1'b0; a_clr_req = 1'b1;
      step();
      n_busy = 0; n_done = 0;
      for (int c = 0; c < 40; c++) begin
         a_we = 1'b0; a_clr_req = 1'b0;
         if (a_busy) n_busy++;
         if (a_done) n_done++;
         if (a_busy && n_busy == inj) begin
            a_we = 1'b1; a_wa = 5'd0; a_wd = 32'd5; a_clr_req = 1'b1;
            #1;
            chk("drop_wa0", 64'(a_drop), 64'd0);
            a_wa = 5'd3;
            #1;
            chk("drop_wa3", 64'(a_drop), 64'd1);
         end
         step();
      end
      a_we = 1'b0; a_clr_req = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      a_we = 0; a_clr_req = 0; a_wa = 0; a_wd = 0; a_ra = 0;
      b_we = 0; b_clr_req = 0; b_wa = 0; b_wd = 0; b_ra = 0;
      #1 rst_n = 1'b0;
      #11;
      a_ra = {5'd9, 5'd3};
      #1;
      chk("rst_busy", 64'(a_busy), 64'd0);
      chk("rst_done", 64'(a_done), 64'd0);
      chk("rst_drop", 64'(a_drop), 64'd0);
      chk("rst_rd0", 64'(a_rd[31:0]), 64'd0);
      chk("rst_rd1", 64'(a_rd[63:32]), 64'd0);
      step();
      rst_n = 1'b1;

      // directed write/read: entry i = i+1
      for (int i = 0; i < 32; i++) begin
         a_we = 1'b1; a_wa = 5'(i); a_wd = 32'(i + 1);
         step();
      end
      a_we = 1'b0;
      for (int i = 0; i < 32; i++) begin
         a_ra = {5'(i), 5'(i)};
         #1;
         chk("wr_rd0", 64'(a_rd[31:0]),  (i == 0) ? 64'd0 : 64'(i + 1));
         chk("wr_rd1", 64'(a_rd[63:32]), (i == 0) ? 64'd0 : 64'(i + 1));
      end
      step();

      // same-cycle hazard on entry 7
      a_we = 1'b1; a_wa = 5'd7; a_wd = 32'h1234;
      step();
      a_wd = 32'hDEAD_BEEF; a_ra = {5'd0, 5'd7};
      #1;
      chk("haz_same", 64'(a_rd[31:0]), BYP ? 64'hDEAD_BEEF : 64'h1234);
      step();
      a_we = 1'b0;
      #1;
      chk("haz_after", 64'(a_rd[31:0]), 64'hDEAD_BEEF);

      // hardwired entry 0 is never written nor forwarded
      a_we = 1'b1; a_wa = 5'd0; a_wd = 32'hCAFE; a_ra = {5'd0, 5'd0};
      #1;
      chk("zero_same", 64'(a_rd[31:0]), 64'd0);
      chk("zero_drop", 64'(a_drop), 64'd0);
      step();
      a_we = 1'b0;
      #1;
      chk("zero_after", 64'(a_rd[31:0]), 64'd0);
      step();

      // full clear sweep
      a_fill(32'hFFFF_FFFF);
      a_sweep(0, nb, nd);
      chk("sw_busy_cycles", 64'(nb), 64'd32);
      chk("sw_done_cycles", 64'(nd), 64'd1);
      a_count_nonzero(nz);
      chk("sw_all_zero", 64'(nz), 64'd0);
      step();

      // write and clr_req during sweep cycle 10
      a_fill(32'h0000_0077);
      a_sweep(10, nb, nd);
      chk("drop_busy_cycles", 64'(nb), 64'd32);
      chk("drop_done_cycles", 64'(nd), 64'd1);
      chk("drop_idle_after", 64'(a_busy), 64'd0);
      a_ra = {5'd0, 5'd3};
      #1;
      chk("drop_entry3", 64'(a_rd[31:0]), 64'd0);
      step();

      // reset in the middle of a sweep
      a_fill(32'hFFFF_FFFF);
      a_clr_req = 1'b1;
      step();
      a_clr_req = 1'b0;
      repeat (11) step();
      chk("mid_busy_before", 64'(a_busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(a_busy), 64'd0);
      chk("mid_rst_done", 64'(a_done), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      nd = 0; nb = 0;
      for (int c = 0; c < 40; c++) begin
         if (a_done) nd++;
         if (a_busy) nb++;
         step();
      end
      chk("mid_no_done", 64'(nd), 64'd0);
      chk("mid_no_busy", 64'(nb), 64'd0);
      a_count_nonzero(nz);
      chk("mid_all_zero", 64'(nz), 64'd0);
      step();

      // instance B: entry 0 is ordinary when ZERO_REG=0
      for (int i = 0; i < 8; i++) m[i] = 16'd0;
      pos = -1; dn = 1'b0;
      b_we = 1'b1; b_wa = 3'd0; b_wd = 16'd1;
      step();
      b_we = 1'b0; b_ra = 12'd0;
      #1;
      chk("b_entry0", 64'(b_rd[15:0]), 64'd1);
      m[0] = 16'd1;

      // randomized run against the shadow model
      for (int n = 0; n < 1000; n++) begin
         step();
         b_we      = 1'($urandom_range(0, 1));
         b_wa      = 3'($urandom_range(0, 7));
         b_wd      = 16'($urandom);
         b_clr_req = ($urandom_range(0, 59) == 0);
         for (int p = 0; p < 4; p++) b_ra[p*3 +: 3] = 3'($urandom_range(0, 7));
         #1;
         busy_e = (pos >= 0);
         acc    = b_we && !busy_e;
         chk("rnd_busy", 64'(b_busy), 64'(busy_e));
         chk("rnd_done", 64'(b_done), 64'(dn));
         chk("rnd_drop", 64'(b_drop), 64'(b_we && busy_e));
         for (int p = 0; p < 4; p++) begin
            ra_v = b_ra[p*3 +: 3];
            e_rd = (BYP && acc && ra_v == b_wa) ? b_wd : m[ra_v];
            chk("rnd_rd", 64'(b_rd[p*16 +: 16]), 64'(e_rd));
         end
         if (busy_e) begin
            m[pos] = 16'd0;
            if (pos == 7) begin
               pos = -1; dn = 1'b1;
            end else begin
               pos++; dn = 1'b0;
            end
         end else begin
            if (acc) m[b_wa] = b_wd;
            dn = 1'b0;
            if (b_clr_req) pos = 0;
         end
      end
      b_we = 1'b0; b_clr_req = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
